pool2d_stream: RTL and testbench

POOL2D_STREAM -- requirements
Module: pool2d_stream

---
 rtl/pool_pkg.sv | 18 +
 rtl/pool_combine.sv | 25 ++
 rtl/pool2d_stream.sv | 173 +++++++++++++++++
 tb/tb_pool2d_stream.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types for the 2x2 stride-2 pooling stream.
//   pool_mode_t  : pooling operator (average / max), latched per frame
//   pool_state_t : frame-level FSM state
package pool_pkg;

    typedef enum logic {
        POOL_AVG = 1'b0,
        POOL_MAX = 1'b1
    } pool_mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } pool_state_t;

endpackage

// File: rtl/pool_combine.sv
// Combinational two-operand pooling stage.
//   a, b : signed operands, IN_W bits
//   mode : POOL_MAX -> larger operand, POOL_AVG -> full-precision sum
//   y    : signed result, IN_W+1 bits (sign-extended max or widened sum)
module pool_combine
    import pool_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic signed [IN_W-1:0] a,
    input  logic signed [IN_W-1:0] b,
    input  pool_mode_t             mode,
    output logic signed [IN_W:0]   y
);

    always_comb begin
        y = '0;
        if (mode == POOL_MAX) begin
            y = (a > b) ? (IN_W+1)'(a) : (IN_W+1)'(b);
        end else begin
            y = (IN_W+1)'(a) + (IN_W+1)'(b);
        end
    end

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2x2 / stride-2 pooling over an FM_W x FM_H raster frame.
//   clk, rst            : clock, asynchronous active-high reset
//   start, mode         : begin frame (IDLE only), 0 = average / 1 = max
//   in_valid/in_ready/in_data    : pixel input handshake, raster order
//   out_valid/out_ready/out_data : pooled output handshake, raster order
//   done                : one-cycle pulse when the frame completes
//   busy                : frame in progress (RUN or FLUSH)
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FM_W   = 6,
    parameter int FM_H   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              done,
    output logic              busy
);

    localparam int COL_W = (FM_W > 1) ? $clog2(FM_W) : 1;
    localparam int ROW_W = (FM_H > 1) ? $clog2(FM_H) : 1;
    localparam int LB_N  = (FM_W / 2 > 0) ? FM_W / 2 : 1;
    localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

    if ((FM_W % 2) != 0 || FM_W < 2 || (FM_H % 2) != 0 || FM_H < 2) begin : g_bad_geometry
        $error("pool2d_stream: FM_W and FM_H must be even and >= 2");
    end

    pool_state_t               state_q, state_d;
    pool_mode_t                mode_q, mode_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic signed [DATA_W-1:0]  h_q, h_d;
    logic signed [DATA_W:0]    lb_q [LB_N];
    logic signed [DATA_W:0]    lb_d [LB_N];
    logic [DATA_W-1:0]         out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;

    logic                      accept;
    logic                      load;
    logic                      last_col;
    logic                      last_row;
    logic [LB_AW-1:0]          lb_idx;
    logic signed [DATA_W:0]    lb_rd;
    logic signed [DATA_W:0]    pair;
    logic signed [DATA_W+1:0]  quad;
    logic signed [DATA_W+1:0]  quad_res;
    logic [DATA_W-1:0]         result;

    assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    // Fourth pixel of a window: odd column on an odd row.
    assign load      = accept && col_q[0] && row_q[0];
    assign last_col  = (col_q == COL_W'(FM_W - 1));
    assign last_row  = (row_q == ROW_W'(FM_H - 1));
    assign lb_idx    = LB_AW'(col_q >> 1);
    assign lb_rd     = lb_q[lb_idx];

    pool_combine #(.IN_W(DATA_W)) u_horiz (
        .a    (h_q),
        .b    ($signed(in_data)),
        .mode (mode_q),
        .y    (pair)
    );

    pool_combine #(.IN_W(DATA_W + 1)) u_vert (
        .a    (lb_rd),
        .b    (pair),
        .mode (mode_q),
        .y    (quad)
    );

    // Arithmetic shift floors toward -inf; truncation drops the guard bits.
    assign quad_res = (mode_q == POOL_AVG) ? (quad >>> 2) : quad;
    assign result   = DATA_W'(quad_res);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        col_d       = col_q;
        row_d       = row_q;
        h_d         = h_q;
        lb_d        = lb_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = pool_mode_t'(mode);
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (!col_q[0]) begin
                        h_d = $signed(in_data);
                    end else if (!row_q[0]) begin
                        lb_d[lb_idx] = pair;
                    end
                    if (last_col) begin
                        col_d = '0;
                        row_d = last_row ? '0 : row_q + ROW_W'(1);
                        if (last_row) begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (!out_valid_q || out_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A result loading on the handshake cycle keeps out_valid asserted.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= POOL_AVG;
            col_q       <= '0;
            row_q       <= '0;
            h_q         <= '0;
            lb_q        <= '{default: '0};
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            col_q       <= col_d;
            row_q       <= row_d;
            h_q         <= h_d;
            lb_q        <= lb_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH);

endmodule

// File: tb/tb_pool2d_stream.sv
module tb_pool2d_stream;

    localparam int DW   = 32;
    localparam int W    = 6;
    localparam int H    = 6;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, mode, in_valid, out_ready;
    logic          in_ready, out_valid, done, busy;
    logic [DW-1:0] in_data, out_data;

    logic          start2, mode2, in_valid2, out_ready2;
    logic          in_ready2, out_valid2, done2, busy2;
    logic [DW-1:0] in_data2, out_data2;

    always #5 clk = ~clk;

    pool2d_stream #(.DATA_W(DW), .FM_W(W), .FM_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done), .busy(busy)
    );

    pool2d_stream #(.DATA_W(DW), .FM_W(2), .FM_H(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .done(done2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;
    int pix [NPIX];
    int exp_q [$];
    int got_q [$];
    int got2_q [$];
    int done_cnt  = 0;
    int done2_cnt = 0;

    // Output monitors: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) got_q.push_back(int'(out_data));
            if (done) done_cnt++;
            if (out_valid2 && out_ready2) got2_q.push_back(int'(out_data2));
            if (done2) done2_cnt++;
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: pool each 2x2 window of pix[] directly from its four pixels.
    function automatic void build_model(input logic m);
        exp_q.delete();
        for (int r = 0; r < H; r += 2) begin
            for (int c = 0; c < W; c += 2) begin
                longint p [4];
                longint v;
                p[0] = pix[r*W + c];
                p[1] = pix[r*W + c + 1];
                p[2] = pix[(r+1)*W + c];
                p[3] = pix[(r+1)*W + c + 1];
                if (m) begin
                    v = p[0];
                    for (int k = 1; k < 4; k++) if (p[k] > v) v = p[k];
                end else begin
                    v = (p[0] + p[1] + p[2] + p[3]) >>> 2;
                end
                exp_q.push_back(int'(v));
            end
        end
    endfunction

    task automatic load_list(input int vals [9]);
        exp_q.delete();
        for (int k = 0; k < 9; k++) exp_q.push_back(vals[k]);
    endtask

    task automatic feed(input logic m, input int npix, input bit rnd_in, input bit rnd_out,
                        input bit stall, input bit disturb);
        int i = 0;
        int cyc = 0;
        bit acc;
        bit stalled = 1'b0;
        got_q.delete();
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        while (i < npix && cyc < 4000) begin
            cyc++;
            in_valid  = rnd_in ? ($urandom_range(3) != 0) : 1'b1;
            in_data   = pix[i];
            out_ready = stall ? stalled : (rnd_out ? ($urandom_range(2) != 0) : 1'b1);
            if (disturb) begin
                start = 1'($urandom_range(1));
                mode  = 1'($urandom_range(1));
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (stall && !stalled && out_valid) begin
                for (int k = 0; k < 10; k++) begin
                    chk("stall_in_ready", 64'(in_ready), 64'(0));
                    chk("stall_out_valid", 64'(out_valid), 64'(1));
                    chk("stall_out_data", 64'($signed(out_data)), 64'(exp_q[0]));
                    @(posedge clk); #1;
                    @(negedge clk);
                end
                stalled = 1'b1;
                acc = 1'b0;
            end
            @(posedge clk); #1;
            if (acc) i++;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        chk("feed_complete", 64'(i), 64'(npix));
    endtask

    task automatic finish_frame(input int base_done);
        int cyc = 0;
        while (done_cnt == base_done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", 64'(done_cnt - base_done), 64'(1));
        chk("busy_idle", 64'(busy), 64'(0));
        chk("out_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_q.size()) chk($sformatf("out_%0d", k), 64'(got_q[k]), 64'(exp_q[k]));
        end
    endtask

    task automatic frame2(input logic m, input int expv);
        int i = 0;
        int cyc = 0;
        int base = done2_cnt;
        bit acc;
        got2_q.delete();
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b1;
        mode2  = m;
        @(posedge clk); #1;
        start2 = 1'b0;
        while (i < 4 && cyc < 100) begin
            cyc++;
            in_valid2 = 1'b1;
            in_data2  = DW'(-(i + 1));
            @(negedge clk);
            acc = in_valid2 && in_ready2;
            @(posedge clk); #1;
            if (acc) i++;
        end
        in_valid2 = 1'b0;
        cyc = 0;
        while (done2_cnt == base && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("fm2_done", 64'(done2_cnt - base), 64'(1));
        chk("fm2_count", 64'(got2_q.size()), 64'(1));
        if (got2_q.size() > 0) chk("fm2_value", 64'(got2_q[0]), 64'(expv));
    endtask

    int ramp_avg [9] = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
    int ramp_max [9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    int extremes [5] = '{32'h8000_0000, 32'h7FFF_FFFF, -1, 0, 1};
    int base;

    initial begin
        rst = 1'b1;
        start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        start2 = 1'b0; mode2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < NPIX; k++) pix[k] = k;

        // Ramp, average then max.
        load_list(ramp_avg);
        base = done_cnt;
        feed(1'b0, NPIX, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_frame(base);

        load_list(ramp_max);
        base = done_cnt;
        feed(1'b1, NPIX, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_frame(base);

        // Consumer stalls for 10 cycles after the first output.
        load_list(ramp_avg);
        base = done_cnt;
        feed(1'b0, NPIX, 1'b0, 1'b0, 1'b1, 1'b0);
        finish_frame(base);

        // Reset after pixel 20, then a clean frame.
        base = done_cnt;
        feed(1'b0, 21, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_out_data", 64'(out_data), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt), 64'(base));
        load_list(ramp_avg);
        base = done_cnt;
        feed(1'b0, NPIX, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_frame(base);

        // start and mode toggled while the frame runs.
        load_list(ramp_avg);
        base = done_cnt;
        feed(1'b0, NPIX, 1'b1, 1'b0, 1'b0, 1'b1);
        finish_frame(base);
        load_list(ramp_max);
        base = done_cnt;
        feed(1'b1, NPIX, 1'b1, 1'b0, 1'b0, 1'b1);
        finish_frame(base);

        // Random frames with random handshakes.
        for (int f = 0; f < 4; f++) begin
            logic m;
            m = 1'($urandom_range(1));
            for (int k = 0; k < NPIX; k++) pix[k] = int'($urandom);
            build_model(m);
            base = done_cnt;
            feed(m, NPIX, 1'b1, 1'b1, 1'b0, 1'b0);
            finish_frame(base);
        end

        // Extreme values exercising sum growth and negative flooring.
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < NPIX; k++) pix[k] = extremes[$urandom_range(4)];
            build_model(f[0]);
            base = done_cnt;
            feed(f[0], NPIX, 1'b1, 1'b1, 1'b0, 1'b0);
            finish_frame(base);
        end

        // Single-window 2x2 frame of negatives.
        frame2(1'b0, -3);
        frame2(1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
